// File: rtl/btb_pkg.sv
// Shared types and counter encodings for the branch target buffer.
package btb_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } btb_state_e;

   // Named encodings of the 2-bit direction counter.
   localparam logic [1:0] SNT = 2'd0;
   localparam logic [1:0] WNT = 2'd1;
   localparam logic [1:0] WT  = 2'd2;
   localparam logic [1:0] ST  = 2'd3;

   // Saturation ceiling of a counter that is ctr_bits wide.
   function automatic int unsigned ctr_max(input int unsigned ctr_bits);
      return (32'd1 << ctr_bits) - 32'd1;
   endfunction

   // Weakly taken: MSB set and all lower bits clear.
   function automatic int unsigned ctr_weak_t(input int unsigned ctr_bits);
      return 32'd1 << (ctr_bits - 32'd1);
   endfunction

endpackage

// File: rtl/btb_pred_table_if.sv
// Fetch-side lookup and decode-side update signals of the branch target buffer.
interface btb_pred_table_if #(
   parameter int WORD_SIZE = 16
);
   logic [WORD_SIZE-1:0] if_pc;
   logic [WORD_SIZE-1:0] if_pred_pc;
   logic                 if_pred_taken;
   logic                 if_hit;

   // upd_valid qualifies upd_* for one cycle and there is no ready: the table
   // takes the update when it is READY and no flush arrives in the same
   // cycle; otherwise the update is silently dropped.
   logic                 upd_valid;
   logic [WORD_SIZE-1:0] upd_pc;
   logic                 upd_is_jump;
   logic                 upd_taken;
   logic [WORD_SIZE-1:0] upd_target;

   modport master (
      output if_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
      input  if_pred_pc, if_pred_taken, if_hit
   );

   modport slave (
      input  if_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
      output if_pred_pc, if_pred_taken, if_hit
   );
endinterface

// File: rtl/btb_sat_ctr.sv
// Combinational saturating up/down step of a direction counter.
module btb_sat_ctr #(
   parameter int CTR_BITS = 2
) (
   input  logic [CTR_BITS-1:0] ctr,
   input  logic                up,
   output logic [CTR_BITS-1:0] next
);

   always_comb begin
      next = ctr;
      if (up) begin
         if (ctr != '1) next = ctr + CTR_BITS'(1);
      end else begin
         if (ctr != '0) next = ctr - CTR_BITS'(1);
      end
   end

endmodule

// File: rtl/btb_pred_table.sv
// Direct-mapped branch target buffer: combinational fetch lookup, registered
// decode update, one-entry-per-cycle clear sweep. Optional BTB_STATS_EN adds counters.
module btb_pred_table
   import btb_pkg::*;
#(
   parameter int WORD_SIZE = 16,
   parameter int IDX_BITS  = 8,
   parameter int CTR_BITS  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   btb_pred_table_if.slave   bus,
   output logic              busy,
   output btb_state_e        dbg_state,
   output logic [31:0]       stat_hits,
   output logic [31:0]       stat_updates
);

   localparam int DEPTH    = 1 << IDX_BITS;
   localparam int TAG_BITS = WORD_SIZE - IDX_BITS;
   localparam logic [CTR_BITS-1:0] CTR_MAX    = CTR_BITS'(ctr_max(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CTR_WEAK_T = CTR_BITS'(ctr_weak_t(CTR_BITS));

   logic                 valid_q  [DEPTH];
   logic [TAG_BITS-1:0]  tag_q    [DEPTH];
   logic [WORD_SIZE-1:0] target_q [DEPTH];
   logic [CTR_BITS-1:0]  ctr_q    [DEPTH];

   btb_state_e           state_q;
   logic [IDX_BITS-1:0]  ptr_q;
   logic                 busy_q;

   logic                 ready;
   logic [IDX_BITS-1:0]  lk_idx;
   logic [TAG_BITS-1:0]  lk_tag;
   logic                 lk_hit;
   logic                 lk_taken;

   logic [IDX_BITS-1:0]  upd_idx;
   logic [TAG_BITS-1:0]  upd_tag;
   logic                 upd_hit;
   logic                 upd_accept;
   logic [CTR_BITS-1:0]  ctr_next;

   // Reset is folded in so the fetch side sees a clean miss while it is held.
   always_comb begin
      ready            = (state_q == READY) && !reset;
      lk_idx           = bus.if_pc[IDX_BITS-1:0];
      lk_tag           = bus.if_pc[WORD_SIZE-1:IDX_BITS];
      lk_hit           = ready && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      lk_taken         = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
      bus.if_hit        = lk_hit;
      bus.if_pred_taken = lk_taken;
      bus.if_pred_pc    = lk_taken ? target_q[lk_idx] : bus.if_pc + WORD_SIZE'(1);
   end

   always_comb begin
      upd_idx    = bus.upd_pc[IDX_BITS-1:0];
      upd_tag    = bus.upd_pc[WORD_SIZE-1:IDX_BITS];
      upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
      upd_accept = ready && bus.upd_valid && !flush;
   end

   btb_sat_ctr #(.CTR_BITS(CTR_BITS)) u_sat_ctr (
      .ctr  (ctr_q[upd_idx]),
      .up   (bus.upd_taken),
      .next (ctr_next)
   );

   // Table arrays have no reset; the INIT sweep is what clears them.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT;
         ptr_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            INIT: begin
               valid_q[ptr_q] <= 1'b0;
               ctr_q[ptr_q]   <= '0;
               ptr_q          <= ptr_q + IDX_BITS'(1);
               if (ptr_q == '1) begin
                  state_q <= READY;
                  busy_q  <= 1'b0;
               end
            end
            READY: begin
               if (flush) begin
                  state_q <= INIT;
                  ptr_q   <= '0;
                  busy_q  <= 1'b1;
               end else if (bus.upd_valid) begin
                  if (bus.upd_is_jump) begin
                     valid_q[upd_idx]  <= 1'b1;
                     tag_q[upd_idx]    <= upd_tag;
                     target_q[upd_idx] <= bus.upd_target;
                     ctr_q[upd_idx]    <= CTR_MAX;
                  end else if (upd_hit) begin
                     ctr_q[upd_idx] <= ctr_next;
                     if (bus.upd_taken) target_q[upd_idx] <= bus.upd_target;
                  end else if (bus.upd_taken) begin
                     valid_q[upd_idx]  <= 1'b1;
                     tag_q[upd_idx]    <= upd_tag;
                     target_q[upd_idx] <= bus.upd_target;
                     ctr_q[upd_idx]    <= CTR_WEAK_T;
                  end
               end
            end
            default: begin
               state_q <= INIT;
               ptr_q   <= '0;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign dbg_state = state_q;

`ifdef BTB_STATS_EN
   logic [31:0] hits_q;
   logic [31:0] upds_q;

   // Flush deliberately leaves these running totals alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         hits_q <= '0;
         upds_q <= '0;
      end else begin
         if (lk_hit)     hits_q <= hits_q + 32'd1;
         if (upd_accept) upds_q <= upds_q + 32'd1;
      end
   end

   assign stat_hits    = hits_q;
   assign stat_updates = upds_q;
`else
   assign stat_hits    = '0;
   assign stat_updates = '0;
`endif

endmodule

// File: tb/tb_btb_pred_table.sv
// Self-checking bench for btb_pred_table: directed scenarios plus random traffic
// compared every cycle against a table model; honours BTB_STATS_EN.
module tb_btb_pred_table;
   import btb_pkg::*;

   localparam int W     = 16;
   localparam int IB    = 8;
   localparam int CB    = 2;
   localparam int DEPTH = 256;
   localparam int SWEEP = 256;
   localparam int C_TOP = 3;
   localparam int C_WT  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        busy;
   btb_state_e  dbg_state;
   logic [31:0] stat_hits;
   logic [31:0] stat_updates;

   btb_pred_table_if #(.WORD_SIZE(W)) bus ();

   btb_pred_table #(.WORD_SIZE(W), .IDX_BITS(IB), .CTR_BITS(CB)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .bus          (bus),
      .busy         (busy),
      .dbg_state    (dbg_state),
      .stat_hits    (stat_hits),
      .stat_updates (stat_updates)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference table: plain arrays indexed by pc % 256, tag = pc / 256.
   bit          m_valid [DEPTH];
   int unsigned m_tag   [DEPTH];
   logic [15:0] m_tgt   [DEPTH];
   int          m_ctr   [DEPTH];
   int          m_sweep = 0;
   logic [31:0] m_hits  = 0;
   logic [31:0] m_upds  = 0;
   bit          started = 0;

   function automatic void m_lookup(input logic [15:0] pc, input bit in_reset,
                                    output bit hit, output bit tk, output logic [15:0] pred);
      int i = int'(pc) % DEPTH;
      hit  = !in_reset && (m_sweep == 0) && m_valid[i] && (m_tag[i] == int'(pc) / DEPTH);
      tk   = hit && (m_ctr[i] >= C_WT);
      pred = tk ? m_tgt[i] : pc + 16'd1;
   endfunction

   function automatic void m_apply(input logic [15:0] pc, input bit jump, input bit tk,
                                   input logic [15:0] tgt);
      int          i   = int'(pc) % DEPTH;
      int unsigned tg  = int'(pc) / DEPTH;
      bit          hit = m_valid[i] && (m_tag[i] == tg);
      if (jump) begin
         m_valid[i] = 1; m_tag[i] = tg; m_tgt[i] = tgt; m_ctr[i] = C_TOP;
      end else if (hit) begin
         if (tk) begin
            m_ctr[i] = (m_ctr[i] < C_TOP) ? m_ctr[i] + 1 : C_TOP;
            m_tgt[i] = tgt;
         end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
         end
      end else if (tk) begin
         m_valid[i] = 1; m_tag[i] = tg; m_tgt[i] = tgt; m_ctr[i] = C_WT;
      end
   endfunction

   bit          s_hit, s_tk;
   logic [15:0] s_pred;

   // Model advances on the same edge the DUT does, from the inputs present at that edge.
   always @(posedge clk) begin
      if (reset) begin
         started = 1;
         m_sweep = SWEEP;
         foreach (m_valid[i]) m_valid[i] = 0;
         m_hits = 0;
         m_upds = 0;
      end else if (m_sweep > 0) begin
         m_sweep--;
      end else begin
         m_lookup(bus.if_pc, 1'b0, s_hit, s_tk, s_pred);
         if (s_hit) m_hits = m_hits + 32'd1;
         if (flush) begin
            m_sweep = SWEEP;
            foreach (m_valid[i]) m_valid[i] = 0;
         end else if (bus.upd_valid) begin
            m_upds = m_upds + 32'd1;
            m_apply(bus.upd_pc, bus.upd_is_jump, bus.upd_taken, bus.upd_target);
         end
      end
   end

   bit          c_hit, c_tk;
   logic [15:0] c_pred;

   always @(negedge clk) begin
      if (started) begin
         m_lookup(bus.if_pc, reset, c_hit, c_tk, c_pred);
         check("cmp_hit",   32'(bus.if_hit),        32'(c_hit));
         check("cmp_taken", 32'(bus.if_pred_taken), 32'(c_tk));
         check("cmp_pred",  32'(bus.if_pred_pc),    32'(c_pred));
         check("cmp_busy",  32'(busy),              32'(m_sweep > 0));
`ifdef BTB_STATS_EN
         check("cmp_stat_hits", stat_hits,    m_hits);
         check("cmp_stat_upds", stat_updates, m_upds);
`else
         check("cmp_stat_hits", stat_hits,    32'd0);
         check("cmp_stat_upds", stat_updates, 32'd0);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      bus.upd_valid = 1'b0;
      flush         = 1'b0;
      reset         = 1'b0;
   endtask

   task automatic set_upd(input logic [15:0] pc, input bit jump, input bit tk, input logic [15:0] tgt);
      bus.upd_valid   = 1'b1;
      bus.upd_pc      = pc;
      bus.upd_is_jump = jump;
      bus.upd_taken   = tk;
      bus.upd_target  = tgt;
   endtask

   task automatic do_upd(input logic [15:0] pc, input bit jump, input bit tk, input logic [15:0] tgt);
      set_upd(pc, jump, tk, tgt);
      tick();
   endtask

   task automatic peek(input logic [15:0] pc, input bit e_hit, input bit e_tk,
                       input logic [15:0] e_pred, input string name);
      bus.if_pc = pc;
      @(negedge clk);
      check({name, "_hit"},   32'(bus.if_hit),        32'(e_hit));
      check({name, "_taken"}, 32'(bus.if_pred_taken), 32'(e_tk));
      check({name, "_pred"},  32'(bus.if_pred_pc),    32'(e_pred));
      tick();
   endtask

   // Counts busy cycles from now; optionally pulses flush again mid-sweep.
   task automatic busy_len(input int reflush_at, input logic [15:0] pc,
                           input logic [15:0] e_pred, output int cnt);
      cnt = 0;
      bus.if_pc = pc;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check("sweep_hit",  32'(bus.if_hit),     32'd0);
            check("sweep_pred", 32'(bus.if_pred_pc), 32'(e_pred));
         end
         if (!busy) break;
         cnt++;
         tick();
         flush = (k == reflush_at);
      end
      flush = 1'b0;
   endtask

   function automatic logic [15:0] pool_pc();
      logic [7:0] idx_set [5];
      logic [7:0] tg;
      idx_set = '{8'h10, 8'h20, 8'h21, 8'hFF, 8'h00};
      tg = ($urandom_range(0, 4) == 4) ? 8'hFF : 8'($urandom_range(0, 3));
      return {tg, idx_set[$urandom_range(0, 4)]};
   endfunction

   int          cnt;
   logic [31:0] saved_hits, saved_upds;

   initial begin
      reset = 1'b1; flush = 1'b0;
      bus.if_pc = '0; bus.upd_valid = 1'b0; bus.upd_pc = '0;
      bus.upd_is_jump = 1'b0; bus.upd_taken = 1'b0; bus.upd_target = '0;
      tick();

      busy_len(-1, 16'h1234, 16'h1235, cnt);
      check("reset_busy_cycles", 32'(cnt), 32'd256);
      tick();

      // Jump allocate, observed in the same cycle (old) and the next (new).
      set_upd(16'h0A10, 1'b1, 1'b0, 16'h0B00);
      peek(16'h0A10, 1'b0, 1'b0, 16'h0A11, "same_cycle_old");
      peek(16'h0A10, 1'b1, 1'b1, 16'h0B00, "jump_hit");
      peek(16'h0B10, 1'b0, 1'b0, 16'h0B11, "jump_tag_miss");

      // Branch hysteresis.
      do_upd(16'h0020, 1'b0, 1'b1, 16'h0040);
      peek(16'h0020, 1'b1, 1'b1, 16'h0040, "br_alloc");
      do_upd(16'h0020, 1'b0, 1'b0, 16'h0000);
      peek(16'h0020, 1'b1, 1'b0, 16'h0021, "br_weak_nt");
      do_upd(16'h0020, 1'b0, 1'b1, 16'h0040);
      do_upd(16'h0020, 1'b0, 1'b1, 16'h0040);
      do_upd(16'h0020, 1'b0, 1'b0, 16'h0000);
      peek(16'h0020, 1'b1, 1'b1, 16'h0040, "br_hyst");

      // Floor and ceiling of the counter.
      for (int k = 0; k < 5; k++) do_upd(16'h0020, 1'b0, 1'b0, 16'h0000);
      do_upd(16'h0020, 1'b0, 1'b1, 16'h0040);
      peek(16'h0020, 1'b1, 1'b0, 16'h0021, "ctr_floor");
      for (int k = 0; k < 3; k++) do_upd(16'h0020, 1'b0, 1'b1, 16'h0040);
      do_upd(16'h0020, 1'b0, 1'b0, 16'h0000);
      peek(16'h0020, 1'b1, 1'b1, 16'h0040, "ctr_ceiling");

      do_upd(16'h0055, 1'b0, 1'b0, 16'h0999);
      peek(16'h0055, 1'b0, 1'b0, 16'h0056, "no_alloc");

      // Flush with a populated table, re-flush mid-sweep is ignored.
      bus.if_pc  = 16'h0055;
      saved_hits = stat_hits;
      saved_upds = stat_updates;
      set_upd(16'h0077, 1'b1, 1'b0, 16'h1111);
      flush = 1'b1;
      tick();
      busy_len(100, 16'h0A10, 16'h0A11, cnt);
      check("flush_busy_cycles", 32'(cnt), 32'd256);
      tick();
      peek(16'h0A10, 1'b0, 1'b0, 16'h0A11, "post_flush_jump");
      peek(16'h0020, 1'b0, 1'b0, 16'h0021, "post_flush_br");
      peek(16'h0077, 1'b0, 1'b0, 16'h0078, "flush_drops_upd");
`ifdef BTB_STATS_EN
      check("stat_hits_kept", stat_hits,    saved_hits);
      check("stat_upds_kept", stat_updates, saved_upds);
`endif

      // Random traffic checked by the per-cycle compare process.
      for (int n = 0; n < 3000; n++) begin
         bus.if_pc = ($urandom_range(0, 9) < 7) ? pool_pc() : 16'($urandom);
         if ($urandom_range(0, 1) == 1)
            set_upd(pool_pc(), $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, 16'($urandom));
         flush = ($urandom_range(0, 299) == 0);
         reset = ($urandom_range(0, 1499) == 0);
         @(posedge clk);
         #1;
         bus.upd_valid = 1'b0;
         flush = 1'b0;
         reset = 1'b0;
      end

      for (int k = 0; k < 300 && busy; k++) tick();
      check("final_idle", 32'(busy), 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/btb_pred_table.md
Name: btb_pred_table

Overview:
- Parametrised branch target buffer for the IF/ID pipeline.
- Holds a valid bit, tag, target and saturating N-bit direction counter per entry.
- IF stage: combinational lookup of predicted next PC.
- ID stage: registered update on resolved branches and jumps.
- Sequential init/flush sweep clears entries one per cycle, so no single-cycle mass reset of the arrays is needed.

Parameters:
- WORD_SIZE, 16, PC and target width in bits.
- IDX_BITS, 8, index width; depth = 2^IDX_BITS entries; tag = PC[WORD_SIZE-1:IDX_BITS].
- CTR_BITS, 2, counter width (>=1); taken when counter MSB = 1.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  one-cycle pulse; starts a re-sweep from READY.
- if_pc  in  WORD_SIZE  PC being fetched.
- if_pred_pc  out  WORD_SIZE  predicted next PC.
- if_pred_taken  out  1  prediction is taken (hit and counter MSB = 1).
- if_hit  out  1  valid entry with matching tag.
- upd_valid  in  1  qualifies the update inputs this cycle.
- upd_pc  in  WORD_SIZE  PC of the resolved instruction.
- upd_is_jump  in  1  1 = unconditional jump; 0 = conditional branch.
- upd_taken  in  1  resolved direction (ignored for jumps).
- upd_target  in  WORD_SIZE  resolved target.
- busy  out  1  sweep in progress.
- stat_hits  out  32  lookup hit counter (optional feature).
- stat_updates  out  32  accepted update counter (optional feature).

Behaviour:
- Address split:
  - idx = pc[IDX_BITS-1:0]
  - tag = pc[WORD_SIZE-1:IDX_BITS]
- FSM states: INIT, READY.
  - reset -> INIT with sweep pointer = 0, independent of the current state, including mid-sweep.
  - INIT: each cycle clears valid[ptr], counter[ptr] = 0, then ptr + 1.
  - INIT -> READY on the cycle after ptr = 2^IDX_BITS - 1 is cleared; the sweep takes exactly 2^IDX_BITS cycles.
  - READY + flush -> INIT with ptr = 0.
  - flush during INIT is ignored; the sweep is not restarted.
- busy = 1 in INIT, 0 in READY.
- Outputs while in INIT or under reset:
  - if_hit = 0, if_pred_taken = 0, if_pred_pc = if_pc + 1.
  - All updates are dropped.
- Lookup (READY, combinational):
  - hit = valid[idx] && tag match.
  - taken = hit && counter[idx][MSB].
  - if_pred_pc = taken ? target[idx] : if_pc + 1; the +1 wraps modulo 2^WORD_SIZE.
- Update (READY, upd_valid = 1), written at posedge:
  - Jump: valid = 1, tag and target written, counter = all ones.
  - Branch, hit, taken: counter + 1, saturating at all ones; target rewritten.
  - Branch, hit, not taken: counter - 1, saturating at 0; target unchanged; entry stays valid.
  - Branch, miss, taken: allocate (overwrite); valid = 1, tag, target; counter = weakly taken (MSB = 1, other bits 0).
  - Branch, miss, not taken: no write.
- A tag mismatch on a valid entry counts as a miss; it is overwritten per the miss rules.
- Same-cycle lookup and update to the same idx: the lookup sees pre-update contents; there is no bypass.
- Update and flush in the same cycle: the update is dropped; the sweep begins next cycle.
- No read latency on lookup; update write latency is 1 cycle.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined:
  - stat_hits increments on every READY cycle with if_hit = 1.
  - stat_updates increments on every accepted update, including no-write branch-miss-not-taken.
  - Both counters wrap at 2^32.
  - Both clear on reset; flush does not clear them.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package btb_pkg:
  - Counter encodings as localparams: SNT = 0, WNT = 1, WT = 2, ST = 3 for CTR_BITS = 2, with generalised CTR_MAX and CTR_WEAK_T.
  - FSM state typedef {INIT, READY}.
- Sub-module btb_sat_ctr (CTR_BITS): combinational saturating increment/decrement, instantiated once on the update path.

Test Plan (defaults):
- Reset: assert reset 1 cycle -> busy = 1 for exactly 256 cycles then 0; during the sweep if_pc = 0x1234 -> if_pred_pc = 0x1235, if_hit = 0.
- Jump allocate: READY; update pc = 0x0A10, jump, target = 0x0B00 -> next cycle if_pc = 0x0A10 gives hit = 1, taken = 1, pred = 0x0B00; if_pc = 0x0B10 (same idx, tag 0x0B) gives hit = 0, pred = 0x0B11.
- Branch hysteresis: branch pc = 0x0020 taken, target = 0x0040 (counter = 2) -> predict 0x0040; one not-taken (counter = 1) -> pred = 0x0021, hit = 1; two taken (counter = 3); one not-taken (counter = 2) -> still predicts 0x0040.
- Saturation/no-alloc: 5 not-taken updates on a hit entry -> counter stays 0; not-taken branch to an empty idx -> if_hit remains 0.
- Collision and same-cycle: lookup 0x0A10 while a jump update writes 0x0A10 the same cycle -> old result that cycle, new result next cycle.
- Flush mid-operation: flush with a populated table -> busy 256 cycles, all lookups miss afterwards; flush again during the sweep -> the sweep ends at the original cycle; with BTB_STATS_EN, stat counters retain their values across the flush.
